// File: rtl/eth_rmii_pkg.sv
// rtl/eth_rmii_pkg.sv - shared RMII constants, FSM encodings and dibit helper
package eth_rmii_pkg;

    localparam logic [7:0] SFD       = 8'hD5;
    localparam logic [7:0] PRE       = 8'h55;
    localparam logic [1:0] DIBIT_PRE = 2'b01;
    localparam logic [1:0] DIBIT_SFD = 2'b11;

    localparam int unsigned SLOT_DIV_10M = 10;
    localparam int unsigned DESER_PHASE  = 4;
    localparam int unsigned SER_PHASE    = 0;

    typedef enum logic [1:0] {D_IDLE, D_PRE, D_DATA, D_DROP} deser_state_t;
    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_IFG} ser_state_t;

    // Dibit k of a byte, k=0 is sent first on the wire.
    function automatic logic [1:0] dibit_of(input logic [7:0] b, input logic [1:0] k);
        return b[{k, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/rmii_slot_gen.sv
// rtl/rmii_slot_gen.sv - dibit slot strobe: every clk at 100M, one clk in ten at 10M
module rmii_slot_gen
    import eth_rmii_pkg::*;
#(
    parameter int unsigned PHASE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic speed_100,
    input  logic restart,
    output logic slot
);

    logic [3:0] cnt;
    logic [3:0] cnt_now;

    // The restart clock itself is count 0, so phase 0 fires on that very clock.
    always_comb begin
        cnt_now = restart ? 4'd0 : cnt;
        slot    = speed_100 | (cnt_now == 4'(PHASE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (restart) begin
            cnt <= 4'd1;
        end else if (cnt == 4'(SLOT_DIV_10M - 1)) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/rmii_phy_endpoint.sv
// rtl/rmii_phy_endpoint.sv - PHY-side RMII endpoint: MAC tx dibits to AXI bytes, AXI bytes to MAC rx dibits
module rmii_phy_endpoint
    import eth_rmii_pkg::*;
#(
    parameter int unsigned PREAMBLE_LEN   = 7,
    parameter int unsigned IFG_BYTES      = 12,
    parameter int unsigned MIN_PRE_DIBITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       speed_100,
    input  logic [1:0] rmii_txd,
    input  logic       rmii_tx_en,
    output logic [1:0] rmii_rxd,
    output logic       rmii_rx_crs_dv,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic       tx_error_no_sfd,
    output logic       rx_error_underflow
);

    localparam int unsigned PRE_DIBITS = PREAMBLE_LEN * 4;
    localparam int unsigned IFG_SLOTS  = IFG_BYTES * 4;

    deser_state_t d_state, d_next;
    logic       d_speed, d_slot, d_restart, tx_en_q;
    logic [3:0] pre_cnt;
    logic       pre_ok;
    logic [5:0] sr;
    logic [1:0] d_dcnt;
    logic [7:0] hold;
    logic       hold_valid;

    assign d_restart = rmii_tx_en & ~tx_en_q;
    assign pre_ok    = pre_cnt >= 4'(MIN_PRE_DIBITS);

    rmii_slot_gen #(.PHASE(DESER_PHASE)) u_deser_slot (
        .clk(clk), .rst(rst), .speed_100(d_speed), .restart(d_restart), .slot(d_slot)
    );

    always_ff @(posedge clk) begin
        if (rst) d_state <= D_IDLE;
        else     d_state <= d_next;
    end

    always_comb begin
        d_next = d_state;
        case (d_state)
            D_IDLE: if (rmii_tx_en) d_next = D_PRE;
            D_PRE: begin
                if (!rmii_tx_en) begin
                    d_next = D_IDLE;
                end else if (d_slot) begin
                    if (rmii_txd == DIBIT_SFD)      d_next = pre_ok ? D_DATA : D_DROP;
                    else if (rmii_txd != DIBIT_PRE) d_next = D_DROP;
                end
            end
            D_DATA, D_DROP: if (!rmii_tx_en) d_next = D_IDLE;
            default: d_next = D_IDLE;
        endcase
    end

    // One byte is always held back so the frame's last byte can carry tlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_speed <= 1'b0; tx_en_q <= 1'b0; pre_cnt <= 4'd0; sr <= 6'd0; d_dcnt <= 2'd0;
            hold <= 8'd0; hold_valid <= 1'b0; m_axis_tdata <= 8'd0; m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0; m_axis_tuser <= 1'b0; tx_error_no_sfd <= 1'b0;
        end else begin
            tx_en_q         <= rmii_tx_en;
            m_axis_tvalid   <= 1'b0;
            m_axis_tlast    <= 1'b0;
            m_axis_tuser    <= 1'b0;
            tx_error_no_sfd <= 1'b0;
            case (d_state)
                D_IDLE: begin
                    d_speed    <= speed_100;
                    pre_cnt    <= 4'd0;
                    d_dcnt     <= 2'd0;
                    hold_valid <= 1'b0;
                end
                D_PRE: begin
                    if (!rmii_tx_en) tx_error_no_sfd <= 1'b1;
                    else if (d_slot && rmii_txd == DIBIT_PRE && !pre_ok) pre_cnt <= pre_cnt + 4'd1;
                end
                D_DROP: if (!rmii_tx_en) tx_error_no_sfd <= 1'b1;
                D_DATA: begin
                    if (!rmii_tx_en) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b1;
                        m_axis_tdata  <= hold_valid ? hold : 8'd0;
                        m_axis_tuser  <= !hold_valid || (d_dcnt != 2'd0);
                    end else if (d_slot) begin
                        sr     <= {rmii_txd, sr[5:2]};
                        d_dcnt <= d_dcnt + 2'd1;
                        if (d_dcnt == 2'd3) begin
                            hold       <= {rmii_txd, sr};
                            hold_valid <= 1'b1;
                            if (hold_valid) begin
                                m_axis_tvalid <= 1'b1;
                                m_axis_tdata  <= hold;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    ser_state_t s_state, s_next;
    logic       s_speed, s_slot, s_restart, byte_due;
    logic [5:0] s_cnt;
    logic [7:0] s_byte;
    logic [1:0] s_dcnt;
    logic       s_last;

    assign s_restart     = (s_state == S_IDLE) && s_axis_tvalid;
    assign byte_due      = (s_state == S_DATA) && s_slot && (s_dcnt == 2'd0) && !s_last;
    assign s_axis_tready = byte_due && s_axis_tvalid;

    rmii_slot_gen #(.PHASE(SER_PHASE)) u_ser_slot (
        .clk(clk), .rst(rst), .speed_100(s_speed), .restart(s_restart), .slot(s_slot)
    );

    always_ff @(posedge clk) begin
        if (rst) s_state <= S_IDLE;
        else     s_state <= s_next;
    end

    // IFG leaves one slot early: the IDLE clock that starts the next frame completes the gap.
    always_comb begin
        s_next = s_state;
        case (s_state)
            S_IDLE:     if (s_axis_tvalid) s_next = S_PREAMBLE;
            S_PREAMBLE: if (s_slot && s_cnt == 6'(PRE_DIBITS - 1)) s_next = S_DATA;
            S_DATA:     if (s_slot && s_dcnt == 2'd0 && (s_last || !s_axis_tvalid)) s_next = S_IFG;
            S_IFG:      if (s_slot && s_cnt == 6'(IFG_SLOTS - 2)) s_next = S_IDLE;
            default:    s_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_speed <= 1'b0; s_cnt <= 6'd0; s_byte <= 8'd0; s_dcnt <= 2'd0; s_last <= 1'b0;
            rmii_rxd <= 2'd0; rmii_rx_crs_dv <= 1'b0; rx_error_underflow <= 1'b0;
        end else begin
            rx_error_underflow <= 1'b0;
            case (s_state)
                S_IDLE: begin
                    s_speed <= speed_100;
                    if (s_axis_tvalid) begin
                        rmii_rx_crs_dv <= 1'b1;
                        rmii_rxd       <= dibit_of(PRE, 2'd0);
                        s_cnt          <= 6'd1;
                        s_dcnt         <= 2'd0;
                        s_last         <= 1'b0;
                    end
                end
                S_PREAMBLE: if (s_slot) begin
                    rmii_rxd <= (s_cnt == 6'(PRE_DIBITS - 1)) ? dibit_of(SFD, 2'd3)
                                                               : dibit_of(PRE, s_cnt[1:0]);
                    s_cnt    <= s_cnt + 6'd1;
                end
                S_DATA: if (s_slot) begin
                    if (s_dcnt != 2'd0) begin
                        rmii_rxd <= dibit_of(s_byte, s_dcnt);
                        s_dcnt   <= s_dcnt + 2'd1;
                    end else if (s_last || !s_axis_tvalid) begin
                        rmii_rx_crs_dv     <= 1'b0;
                        rmii_rxd           <= 2'd0;
                        s_cnt              <= 6'd0;
                        rx_error_underflow <= !s_last;
                    end else begin
                        rmii_rxd <= s_axis_tdata[1:0];
                        s_byte   <= s_axis_tdata;
                        s_last   <= s_axis_tlast;
                        s_dcnt   <= 2'd1;
                    end
                end
                S_IFG: if (s_slot) s_cnt <= s_cnt + 6'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rmii_phy_endpoint.sv
// tb/tb_rmii_phy_endpoint.sv - directed self-checking bench for rmii_phy_endpoint
module tb_rmii_phy_endpoint;

    logic       clk = 1'b0;
    logic       rst, speed_100, rmii_tx_en, rmii_rx_crs_dv;
    logic [1:0] rmii_txd, rmii_rxd;
    logic [7:0] m_axis_tdata, s_axis_tdata;
    logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic       s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic       tx_error_no_sfd, rx_error_underflow;

    rmii_phy_endpoint dut (
        .clk(clk), .rst(rst), .speed_100(speed_100),
        .rmii_txd(rmii_txd), .rmii_tx_en(rmii_tx_en),
        .rmii_rxd(rmii_rxd), .rmii_rx_crs_dv(rmii_rx_crs_dv),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .tx_error_no_sfd(tx_error_no_sfd), .rx_error_underflow(rx_error_underflow)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0] beats[$];
    int         beat_cyc[$];
    logic [1:0] rx_dibits[$];
    int         frame_lens[$];
    int no_sfd_clks = 0, underflow_clks = 0;
    int gap_run = 0, last_gap = 0, crs_run = 0;
    logic crs_prev = 1'b0;

    always @(negedge clk) begin
        if (m_axis_tvalid) begin
            beats.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
            beat_cyc.push_back(cyc);
        end
        if (tx_error_no_sfd)    no_sfd_clks++;
        if (rx_error_underflow) underflow_clks++;
        if (rmii_rx_crs_dv) begin
            rx_dibits.push_back(rmii_rxd);
            if (!crs_prev && gap_run > 0) last_gap = gap_run;
            gap_run = 0;
            crs_run++;
        end else if (crs_prev) begin
            frame_lens.push_back(crs_run);
            crs_run = 0;
            gap_run = 1;
        end else if (gap_run > 0) begin
            gap_run++;
        end
        crs_prev = rmii_rx_crs_dv;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] frame_bytes [0:3] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic [1:0] exp_data [0:7]   = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
    int b2_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic dibit(input logic [1:0] d, input int hold);
        rmii_tx_en = 1'b1;
        rmii_txd   = d;
        repeat (hold) @(negedge clk);
    endtask

    task automatic mac_frame(input int nbytes, input int extra, input int hold);
        for (int i = 0; i < 27; i++) dibit(2'b01, hold);
        dibit(2'b11, hold);
        for (int i = 0; i < nbytes; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (i == 1 && k == 3) b2_cyc = cyc;
                dibit(frame_bytes[i][2*k +: 2], hold);
            end
        end
        for (int k = 0; k < extra; k++) dibit(frame_bytes[nbytes][2*k +: 2], hold);
        rmii_tx_en = 1'b0;
        rmii_txd   = 2'b00;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beats.delete();
        beat_cyc.delete();
        no_sfd_clks = 0;
    endtask

    bit ok;
    int n_beats, n_sfd, n_uf;

    initial begin
        rst = 1'b1; speed_100 = 1'b1; rmii_tx_en = 1'b0; rmii_txd = 2'b00;
        s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outputs", {rmii_rxd, rmii_rx_crs_dv, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
              m_axis_tuser, s_axis_tready, tx_error_no_sfd, rx_error_underflow}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 100M MAC->PHY: 01 02 03
        clear_mon();
        mac_frame(3, 0, 1);
        repeat (10) @(negedge clk);
        check("m100_count", beats.size(), 3);
        check("m100_beat0", beats[0], 10'h001);
        check("m100_beat1", beats[1], 10'h002);
        check("m100_beat2", beats[2], 10'h203);
        check("m100_first_cyc", beat_cyc[0], b2_cyc + 1);

        // 10M MAC->PHY: same frame, 10 clk per dibit
        speed_100 = 1'b0;
        repeat (5) @(negedge clk);
        clear_mon();
        mac_frame(3, 0, 10);
        repeat (30) @(negedge clk);
        check("m10_count", beats.size(), 3);
        check("m10_beat0", beats[0], 10'h001);
        check("m10_beat1", beats[1], 10'h002);
        check("m10_beat2", beats[2], 10'h203);
        check("m10_spacing", beat_cyc[1] - beat_cyc[0], 40);

        // Odd end: two dibits into the 4th byte
        speed_100 = 1'b1;
        repeat (5) @(negedge clk);
        clear_mon();
        mac_frame(3, 2, 1);
        repeat (10) @(negedge clk);
        check("odd_count", beats.size(), 3);
        check("odd_beat0", beats[0], 10'h001);
        check("odd_beat2", beats[2], 10'h303);

        // tx_en falls in DATA before any complete byte
        clear_mon();
        mac_frame(0, 2, 1);
        repeat (10) @(negedge clk);
        check("nobyte_count", beats.size(), 1);
        check("nobyte_beat", beats[0], 10'h300);
        check("nobyte_no_sfd", no_sfd_clks, 0);

        // No SFD: 20 dibits of 01
        clear_mon();
        for (int i = 0; i < 20; i++) dibit(2'b01, 1);
        rmii_tx_en = 1'b0;
        repeat (10) @(negedge clk);
        check("nosfd_beats", beats.size(), 0);
        check("nosfd_pulse", no_sfd_clks, 1);

        // PHY->MAC 100M: AA BB(last), then CC(last) waits out the gap
        rx_dibits.delete(); frame_lens.delete(); last_gap = 0;
        s_axis_tdata = 8'hAA; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        wait_ready(ok);
        check("ser_accept_aa", ok, 1);
        s_axis_tdata = 8'hBB; s_axis_tlast = 1'b1;
        wait_ready(ok);
        check("ser_accept_bb", ok, 1);
        s_axis_tdata = 8'hCC; s_axis_tlast = 1'b1;
        wait_ready(ok);
        check("ser_accept_cc", ok, 1);
        s_axis_tvalid = 1'b0;
        repeat (20) @(negedge clk);
        check("ser_len0", frame_lens[0], 36);
        for (int i = 0; i < 27; i++) check("ser_pre_dibit", rx_dibits[i], 2'b01);
        check("ser_sfd_dibit", rx_dibits[27], 2'b11);
        for (int i = 0; i < 8; i++) check("ser_data_dibit", rx_dibits[28 + i], exp_data[i]);
        check("ser_gap", last_gap, 48);
        check("ser_len1", frame_lens[1], 32);
        check("ser_no_underflow", underflow_clks, 0);

        // Underflow: DD accepted, then tvalid drops
        repeat (80) @(negedge clk);
        s_axis_tdata = 8'hDD; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        wait_ready(ok);
        check("uf_accept", ok, 1);
        s_axis_tvalid = 1'b0;
        repeat (20) @(negedge clk);
        check("uf_pulse", underflow_clks, 1);
        check("uf_len", frame_lens[2], 32);
        check("uf_crs_low", rmii_rx_crs_dv, 0);

        // Reset with both directions mid-frame
        repeat (80) @(negedge clk);
        s_axis_tdata = 8'hEE; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        for (int i = 0; i < 27; i++) dibit(2'b01, 1);
        dibit(2'b11, 1);
        for (int k = 0; k < 4; k++) dibit(frame_bytes[0][2*k +: 2], 1);
        dibit(2'b10, 1);
        dibit(2'b00, 1);
        check("rst_pre_crs", rmii_rx_crs_dv, 1);
        n_beats = beats.size(); n_sfd = no_sfd_clks; n_uf = underflow_clks;
        rst = 1'b1; rmii_tx_en = 1'b0; s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_outputs", {rmii_rxd, rmii_rx_crs_dv, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
              s_axis_tready, tx_error_no_sfd, rx_error_underflow}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rst_no_beat", beats.size(), n_beats);
        check("rst_no_sfd_err", no_sfd_clks, n_sfd);
        check("rst_no_uf_err", underflow_clks, n_uf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
